// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/subtract one nibble per cycle through an external 4-bit CLA slice; define NSA_OVF_FLAG_EN to enable the signed overflow flag
module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_sum,
  input  logic             cla_cout,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);
  localparam int N = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic carry;
  logic last;
  assign last = idx == IW'(N - 1);
  assign cla_a = state == RUN ? a_reg[{idx, 2'b00} +: 4] : 4'd0;
  assign cla_b = state == RUN ? b_reg[{idx, 2'b00} +: 4] : 4'd0;
  assign cla_cin = state == RUN ? carry : 1'b0;
`ifndef NSA_OVF_FLAG_EN
  assign ovf = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      carry <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef NSA_OVF_FLAG_EN
      ovf <= 1'b0;
`endif
    end else if (state == RUN) begin
      sum[{idx, 2'b00} +: 4] <= cla_sum;
      carry <= cla_cout;
      idx <= last ? idx : idx + 1'b1;
      if (last) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
        cout <= cla_cout;
`ifdef NSA_OVF_FLAG_EN
        ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (cla_sum[3] != a_reg[WIDTH-1]);
`endif
      end
    end else if (start) begin
      state <= RUN;
      busy <= 1'b1;
      done <= 1'b0;
      a_reg <= a;
      b_reg <= sub ? ~b : b;
      carry <= sub | cin;
      idx <= '0;
    end else begin
      state <= IDLE;
      done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: randomized scoreboard bench for nibble_serial_adder with a behavioural CLA slice and arithmetic reference model
module tb_nibble_serial_adder;
  localparam int WIDTH = 32;
  localparam int N = WIDTH / 4;
  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cin = 1'b0;
  logic sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0] cla_a;
  logic [3:0] cla_b;
  logic cla_cin;
  logic [3:0] cla_sum;
  logic cla_cout;
  logic [31:0] sum;
  logic cout;
  logic ovf;
  logic busy;
  logic done;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t held = '0;
  exp_t mon_e;
  logic prev_done = 1'b0;
  logic [31:0] corners [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin), .cla_sum(cla_sum), .cla_cout(cla_cout),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );
  assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
    exp_t e;
    logic [32:0] u;
    longint sr;
    u = {1'b0, x} + {1'b0, y} + {32'b0, ci};
    e.sum = s ? x - y : u[31:0];
    e.cout = s ? (x >= y) : u[32];
    sr = s ? longint'($signed(x)) - longint'($signed(y))
           : longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
`ifdef NSA_OVF_FLAG_EN
    e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`else
    e.ovf = 1'b0;
    if (sr == 0) e.ovf = 1'b0;
`endif
    return e;
  endfunction
  function automatic logic [31:0] pick();
    int r;
    r = $urandom_range(0, 6);
    return r < 4 ? corners[r] : $urandom;
  endfunction
  task automatic drive_op(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
    a = x;
    b = y;
    cin = ci;
    sub = s;
    q.push_back(model(x, y, ci, s));
  endtask
  task automatic wait_done(input bit junk, output int cyc, output int bc);
    cyc = 0;
    bc = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!done) begin
        bc += busy ? 1 : 0;
        if (junk) begin
          a = $urandom;
          b = $urandom;
          cin = 1'($urandom);
          sub = 1'($urandom);
        end
      end
    end
    chk("done_timeout", done, 1);
  endtask
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
    int cyc;
    int bc;
    @(posedge clk);
    #1;
    chk("hold_result", {sum, cout, ovf}, {held.sum, held.cout, held.ovf});
    start = 1'b1;
    drive_op(x, y, ci, s);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_done(1'b0, cyc, bc);
    chk("latency", cyc, N);
    chk("busy_cycles", bc, N);
    chk("busy_at_done", busy, 0);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (!busy) chk("cla_idle", {cla_a, cla_b, cla_cin}, 0);
      if (done) begin
        chk("done_width", prev_done, 0);
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL done_expected: done pulse with no pending operation, expected none");
        end else begin
          mon_e = q.pop_front();
          chk("sum", sum, mon_e.sum);
          chk("cout", cout, mon_e.cout);
          chk("ovf", ovf, mon_e.ovf);
          held = mon_e;
        end
      end
      prev_done = done;
    end
  end
  initial begin
    int cyc;
    int bc;
    logic dn;
    start = 1'b1;
    a = $urandom;
    b = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", {sum, cout, ovf}, 0);
    chk("rst_cla", {cla_a, cla_b, cla_cin}, 0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    run_op(32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0);
    chk("d1_sum", sum, 32'h0000_0010);
    chk("d1_cout", cout, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    chk("d2_sum", sum, 32'h0000_0000);
    chk("d2_cout", cout, 1);
    chk("d2_ovf", ovf, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    chk("d3_sum", sum, 32'h8000_0000);
    chk("d3_cout", cout, 0);
`ifdef NSA_OVF_FLAG_EN
    chk("d3_ovf", ovf, 1);
`else
    chk("d3_ovf", ovf, 0);
`endif
    run_op(32'd5, 32'd7, 1'b1, 1'b1);
    chk("d4_sum", sum, 32'hFFFF_FFFE);
    chk("d4_cout", cout, 0);
    run_op(32'd7, 32'd5, 1'b0, 1'b1);
    chk("d5_sum", sum, 32'd2);
    chk("d5_cout", cout, 1);
    for (int i = 0; i < 24; i++) run_op(pick(), pick(), 1'($urandom), 1'($urandom));
    @(posedge clk);
    #1;
    start = 1'b1;
    drive_op(pick(), pick(), 1'($urandom), 1'($urandom));
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      wait_done(1'b1, cyc, bc);
      chk("b2b_latency", cyc, N);
      chk("b2b_busy_cycles", bc, N);
      if (i < 5) drive_op(pick(), pick(), 1'($urandom), 1'($urandom));
      else start = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("b2b_idle_busy", busy, 0);
    start = 1'b1;
    drive_op($urandom, $urandom, 1'($urandom), 1'($urandom));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete(q.size() - 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    held = '0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    dn = 1'b0;
    repeat (3 * N) begin
      @(posedge clk);
      #1;
      dn |= done;
    end
    chk("abort_no_done", dn, 0);
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
